// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - float32 field definitions and unpack helper shared by the IIR chain
//
// Purpose: common float32 view for the IIR, its input converter and the
//          float-to-fixed output stage.
// Contents: float_t, exponent/mantissa constants, fp_class_t, fp_unpacked_t,
//           fp_unpack() (splits a float32 and classifies it; denormals are ZERO).

package fp_pkg;

    typedef logic [31:0] float_t;

    localparam int FP_EXP_BIAS  = 127;
    localparam int FP_MANT_BITS = 23;
    localparam int FP_EXP_MAX   = 255;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;   // hidden one restored
        fp_class_t   cls;
    } fp_unpacked_t;

    function automatic fp_unpacked_t fp_unpack(input float_t f);
        fp_unpacked_t r;
        r.sign = f[31];
        r.exp  = f[30:23];
        r.mant = {1'b1, f[22:0]};
        if (f[30:23] == 8'd0) begin
            r.cls = FP_ZERO;
        end else if (f[30:23] == 8'(FP_EXP_MAX)) begin
            r.cls = (f[22:0] != 23'd0) ? FP_NAN : FP_INF;
        end else begin
            r.cls = FP_NORMAL;
        end
        return r;
    endfunction

endpackage

// File: rtl/float_to_fixed_stream_if.sv
// rtl/float_to_fixed_stream_if.sv - sample stream bundle for the float-to-fixed stage
//
// Purpose: groups the float32 input stream and the fixed-point output stream.
// Signals: din/din_valid/din_ready   float32 samples into the stage
//          dout/dout_valid/dout_ready fixed-point samples out of the stage
// Modports: slave  - the conversion stage
//           master - the producer/consumer around it

interface float_to_fixed_stream_if #(
    parameter int G_OUT_WIDTH = 24
);
    import fp_pkg::*;

    float_t                 din;
    logic                   din_valid;
    logic                   din_ready;
    logic [G_OUT_WIDTH-1:0] dout;
    logic                   dout_valid;
    logic                   dout_ready;

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

endinterface

// File: rtl/fixed_round_sat.sv
// rtl/fixed_round_sat.sv - shift, round-half-even and saturate a mantissa into a signed word
//
// Purpose: combinational second-stage datapath of float_to_fixed_stream.
// Ports: mant  in  24  mantissa with hidden one (0 means a zero result)
//        shift in  10  signed binary-point shift; positive = left
//        sign  in   1  sign applied after rounding
//        value out  W  two's complement result, saturated
//        sat   out  1  result was clipped to MAX or MIN

module fixed_round_sat #(
    parameter int G_OUT_WIDTH = 24
) (
    input  logic [23:0]            mant,
    input  logic signed [9:0]      shift,
    input  logic                   sign,
    output logic [G_OUT_WIDTH-1:0] value,
    output logic                   sat
);

    // Wide enough for a 24-bit mantissa shifted left by up to G_OUT_WIDTH.
    localparam int MAG_W = G_OUT_WIDTH + 25;
    localparam logic [MAG_W-1:0] POS_LIMIT = (MAG_W'(1) << (G_OUT_WIDTH - 1)) - MAG_W'(1);
    localparam logic [MAG_W-1:0] NEG_LIMIT = MAG_W'(1) << (G_OUT_WIDTH - 1);

    logic [MAG_W-1:0] mag;
    logic             ovf;
    logic [9:0]       rshift;
    logic [4:0]       rs;
    logic [24:0]      m25;
    logic [24:0]      kept;
    logic [24:0]      mask;
    logic             guard;
    logic             sticky;

    always_comb begin
        mag    = '0;
        ovf    = 1'b0;
        rshift = '0;
        rs     = '0;
        m25    = {1'b0, mant};
        kept   = '0;
        mask   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        value  = '0;
        sat    = 1'b0;

        if (!shift[9]) begin
            // Any shift beyond the word width already overflows for a nonzero
            // mantissa; catching it here keeps the shift itself from wrapping.
            if (shift > $signed(10'(G_OUT_WIDTH))) begin
                ovf = (mant != 24'd0);
            end else begin
                mag = MAG_W'(mant) << shift;
            end
        end else begin
            rshift = 10'(-shift);
            // From 26 places on even the guard bit lies above the mantissa.
            if (rshift < 10'd26) begin
                rs     = rshift[4:0];
                kept   = m25 >> rs;
                guard  = m25[rs - 5'd1];
                mask   = (25'd1 << (rs - 5'd1)) - 25'd1;
                sticky = |(m25 & mask);
                mag    = MAG_W'(kept) + MAG_W'(guard & (sticky | kept[0]));
            end
        end

        if (!sign) begin
            if (ovf || mag > POS_LIMIT) begin
                value = {1'b0, {(G_OUT_WIDTH-1){1'b1}}};
                sat   = 1'b1;
            end else begin
                value = mag[G_OUT_WIDTH-1:0];
            end
        end else begin
            // Exactly -2^(W-1) is representable, so only larger magnitudes clip.
            if (ovf || mag > NEG_LIMIT) begin
                value = {1'b1, {(G_OUT_WIDTH-1){1'b0}}};
                sat   = 1'b1;
            end else begin
                // Negating a zero magnitude gives 0, so -0 never appears.
                value = '0 - mag[G_OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/float_to_fixed_stream.sv
// rtl/float_to_fixed_stream.sv - float32 stream to signed fixed-point stream, 2-stage elastic
//
// Purpose: converts the IIR float32 output into Q(W-F).F words for the DAC/I2S
//          path with round-half-to-even, saturation and a saturation counter.
// Ports: clk, reset      clock, synchronous active-high reset
//        enable          0 flushes the pipeline and clears the counter
//        bus (slave)     din/din_valid/din_ready in, dout/dout_valid/dout_ready out
//        sat_clear       synchronous clear of sat_count/sat_flag
//        sat_count       saturated samples handed off, sticks at 0xFFFF
//        sat_flag        sticky saturated-handoff flag

module float_to_fixed_stream
    import fp_pkg::*;
#(
    parameter int G_OUT_WIDTH = 24,
    parameter int G_FRAC_BITS = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    float_to_fixed_stream_if.slave  bus,
    input  logic                    sat_clear,
    output logic [15:0]             sat_count,
    output logic                    sat_flag
);

    localparam logic [9:0] EXP_BIAS  = 10'(FP_EXP_BIAS);
    localparam logic [9:0] SHIFT_ADJ = 10'(G_FRAC_BITS - FP_MANT_BITS);
    // Large enough to force overflow in fixed_round_sat for any width.
    localparam logic signed [9:0] INF_SHIFT = 10'sd511;

    logic clr;
    assign clr = reset | ~enable;

    // S1 registers: unpacked sample
    logic                   s1_valid;
    logic                   s1_sign;
    logic [23:0]            s1_mant;
    logic signed [9:0]      s1_shift;

    // S2 registers: finished fixed-point sample
    logic                   s2_valid;
    logic                   s2_sat;
    logic [G_OUT_WIDTH-1:0] s2_data;

    logic s1_accept;
    logic s2_accept;

    assign s2_accept     = ~s2_valid | bus.dout_ready;
    assign s1_accept     = ~s1_valid | s2_accept;
    assign bus.din_ready = s1_accept;
    assign bus.dout      = s2_data;
    assign bus.dout_valid = s2_valid;

    fp_unpacked_t      u;
    logic [23:0]       u_mant;
    logic signed [9:0] u_shift;
    logic signed [9:0] norm_shift;

    assign u = fp_unpack(bus.din);

    // ZERO and NaN become a zero mantissa; INF becomes a forced overflow so
    // the S2 datapath saturates it toward its sign.
    always_comb begin
        u_mant     = 24'd0;
        u_shift    = 10'sd0;
        norm_shift = $signed({2'b00, u.exp} - EXP_BIAS + SHIFT_ADJ);
        case (u.cls)
            FP_NORMAL: begin
                u_mant  = u.mant;
                u_shift = norm_shift;
            end
            FP_INF: begin
                u_mant  = 24'h800000;
                u_shift = INF_SHIFT;
            end
            default: begin
                u_mant  = 24'd0;
                u_shift = 10'sd0;
            end
        endcase
    end

    logic [G_OUT_WIDTH-1:0] rs_value;
    logic                   rs_sat;

    fixed_round_sat #(
        .G_OUT_WIDTH (G_OUT_WIDTH)
    ) u_round_sat (
        .mant  (s1_mant),
        .shift (s1_shift),
        .sign  (s1_sign),
        .value (rs_value),
        .sat   (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mant  <= '0;
            s1_shift <= '0;
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s1_accept) begin
                s1_valid <= bus.din_valid;
                if (bus.din_valid) begin
                    s1_sign  <= u.sign;
                    s1_mant  <= u_mant;
                    s1_shift <= u_shift;
                end
            end
            if (s2_accept) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= rs_value;
                    s2_sat  <= rs_sat;
                end
            end
        end
    end

    // Counted at handoff so samples dropped by a flush never count.
    always_ff @(posedge clk) begin
        if (clr || sat_clear) begin
            sat_count <= '0;
            sat_flag  <= 1'b0;
        end else if (s2_valid && bus.dout_ready && s2_sat) begin
            sat_flag <= 1'b1;
            if (sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_float_to_fixed_stream.sv
// tb/tb_float_to_fixed_stream.sv - self-checking bench for float_to_fixed_stream

module tb_float_to_fixed_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sat_clear;
    logic [15:0] sat_count;
    logic        sat_flag;

    float_to_fixed_stream_if #(.G_OUT_WIDTH(24)) bus ();

    float_to_fixed_stream #(
        .G_OUT_WIDTH (24),
        .G_FRAC_BITS (23)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .sat_clear (sat_clear),
        .sat_count (sat_count),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic [23:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: whenever dout is valid it must match the oldest expected
    // value (this also proves it is held while stalled); pop on handshake.
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("out_without_expect", sb.size(), 1);
            end else begin
                check("dout", {8'h00, bus.dout}, {8'h00, sb[0]});
                if (bus.dout_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [23:0] e);
        bus.din       = x;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.din_ready) break;
        end
        check("send_ready", {31'd0, bus.din_ready}, 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.din_valid = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    logic [31:0] bp_in  [6] = '{32'h3F000000, 32'hBF000000, 32'h3E800000,
                                32'hBF800000, 32'h3F400000, 32'h3FC00000};
    logic [23:0] bp_exp [6] = '{24'h400000, 24'hC00000, 24'h200000,
                                24'h800000, 24'h600000, 24'h7FFFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int out_base;

        reset          = 1'b1;
        enable         = 1'b1;
        sat_clear      = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_dout_valid", {31'd0, bus.dout_valid}, 0);
        check("rst_dout", {8'h00, bus.dout}, 0);
        check("rst_sat_count", {16'd0, sat_count}, 0);
        check("rst_sat_flag", {31'd0, sat_flag}, 0);
        check("rst_din_ready", {31'd0, bus.din_ready}, 1);

        // Nominal 0.5 and two-clock latency
        send(32'h3F000000, 24'h400000);
        bus.din_valid = 1'b0;
        check("lat_edge1_valid", {31'd0, bus.dout_valid}, 0);
        @(posedge clk); #1;
        check("lat_edge2_valid", {31'd0, bus.dout_valid}, 1);
        check("lat_edge2_dout", {8'h00, bus.dout}, 32'h400000);
        drain();

        // Full-scale edges
        send(32'hBF800000, 24'h800000);
        drain();
        check("neg_one_sat_count", {16'd0, sat_count}, 0);
        send(32'h3F800000, 24'h7FFFFF);
        drain();
        check("pos_one_sat_count", {16'd0, sat_count}, 1);
        check("pos_one_sat_flag", {31'd0, sat_flag}, 1);

        // Rounding, denormal, NaN
        send(32'h33800000, 24'h000000);
        send(32'h34400000, 24'h000002);
        send(32'h00000001, 24'h000000);
        send(32'h7FC00000, 24'h000000);
        drain();
        check("round_nan_sat_count", {16'd0, sat_count}, 1);

        // -inf and a large positive value
        send(32'hFF800000, 24'h800000);
        send(32'h47000000, 24'h7FFFFF);
        drain();
        check("specials_sat_count", {16'd0, sat_count}, 3);

        // Backpressure: consumer stalled for 5 clk
        out_base       = n_out;
        idx            = 0;
        bus.dout_ready = 1'b0;
        bus.din        = bp_in[0];
        bus.din_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.din_ready && idx < 6) begin
                sb.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 6) bus.din = bp_in[idx];
        end
        check("bp_accepts_stalled", idx, 2);
        check("bp_din_ready_stalled", {31'd0, bus.din_ready}, 0);
        bus.dout_ready = 1'b1;
        for (int t = 0; t < 50 && idx < 6; t++) begin
            @(negedge clk);
            if (bus.din_ready) begin
                sb.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 6) bus.din = bp_in[idx];
        end
        check("bp_accepts_total", idx, 6);
        drain();
        check("bp_outputs", n_out - out_base, 6);
        check("bp_sat_count", {16'd0, sat_count}, 4);

        // Reset mid-stream with both stages full
        bus.dout_ready = 1'b0;
        send(32'h3F000000, 24'h400000);
        send(32'h3E800000, 24'h200000);
        bus.din_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check("midrst_dout_valid", {31'd0, bus.dout_valid}, 0);
        check("midrst_dout", {8'h00, bus.dout}, 0);
        check("midrst_sat_count", {16'd0, sat_count}, 0);
        check("midrst_sat_flag", {31'd0, sat_flag}, 0);
        @(posedge clk); #1;
        check("midrst_s1_flushed", {31'd0, bus.dout_valid}, 0);
        bus.dout_ready = 1'b1;

        // sat_clear coinciding with a saturated handoff
        send(32'hFF800000, 24'h800000);
        drain();
        check("pre_clear_sat_count", {16'd0, sat_count}, 1);
        bus.dout_ready = 1'b0;
        send(32'h3F800000, 24'h7FFFFF);
        bus.din_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.dout_valid; i++) begin
            @(posedge clk); #1;
        end
        check("clear_wait_valid", {31'd0, bus.dout_valid}, 1);
        sat_clear      = 1'b1;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        check("clear_sat_count", {16'd0, sat_count}, 0);
        check("clear_sat_flag", {31'd0, sat_flag}, 0);
        check("clear_handoff_done", sb.size(), 0);

        // enable low for one clock acts as reset
        send(32'h3F800000, 24'h7FFFFF);
        drain();
        check("pre_en_sat_count", {16'd0, sat_count}, 1);
        bus.dout_ready = 1'b0;
        send(32'h3F000000, 24'h400000);
        send(32'hBF000000, 24'hC00000);
        bus.din_valid = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        sb.delete();
        check("en_dout_valid", {31'd0, bus.dout_valid}, 0);
        check("en_dout", {8'h00, bus.dout}, 0);
        check("en_sat_count", {16'd0, sat_count}, 0);
        check("en_sat_flag", {31'd0, sat_flag}, 0);
        @(posedge clk); #1;
        check("en_s1_flushed", {31'd0, bus.dout_valid}, 0);
        bus.dout_ready = 1'b1;

        // Recovery after flush
        send(32'h3E800000, 24'h200000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
